pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/processor_pkg.sv | 46 ++++
 rtl/return_stack.sv | 68 ++++++
 rtl/pc_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// ---------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the fetch-side PC logic: PC width, return-stack
// geometry, opcode encodings and the pc_unit FSM state type.
// No ports; imported with "import processor_pkg::*;".
// ---------------------------------------------------------------------------
package processor_pkg;

   localparam int PC_W      = 16;
   localparam int RAS_DEPTH = 4;
   localparam int RAS_PTR_W = 2;
   localparam int RAS_CNT_W = 3;

   // The count has to reach RAS_DEPTH itself, so it needs one bit more than the pointer
   localparam logic [RAS_CNT_W-1:0] RAS_CNT_MAX = 3'(RAS_DEPTH);

   localparam logic [3:0] OP_JMP  = 4'b0100;
   localparam logic [3:0] OP_CALL = 4'b0101;
   localparam logic [3:0] OP_RET  = 4'b0110;
   localparam logic [3:0] OP_BGT  = 4'b1000;
   localparam logic [3:0] OP_BGTZ = 4'b1001;
   localparam logic [3:0] OP_BLT  = 4'b1010;
   localparam logic [3:0] OP_BLTZ = 4'b1011;
   localparam logic [3:0] OP_BEQ  = 4'b1100;
   localparam logic [3:0] OP_BEQZ = 4'b1101;
   localparam logic [3:0] OP_BNE  = 4'b1110;
   localparam logic [3:0] OP_BNEZ = 4'b1111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pcState_t;

   // All conditional branches share one rule: taken when the comparator says so
   function automatic logic isBranchOp(input logic [3:0] op);
      logic result;
      result = 1'b0;
      case (op)
         OP_BGT, OP_BGTZ, OP_BLT, OP_BLTZ,
         OP_BEQ, OP_BEQZ, OP_BNE, OP_BNEZ: result = 1'b1;
         default:                          result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
// Small circular return-address stack used for CALL/RET prediction-free
// returns. Pushing when full overwrites the oldest entry; popping when empty
// leaves the stack untouched (the caller decides what to do about it).
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset (pointer and count only)
//   i_push   in   write i_din on top of the stack
//   i_pop    in   discard the top entry
//   i_din    in   return address to push
//   o_dout   out  current top entry (valid only when o_empty = 0)
//   o_full   out  RAS_DEPTH entries held
//   o_empty  out  no entries held
// ---------------------------------------------------------------------------
module return_stack
   import processor_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic [PC_W-1:0] i_din,
   output logic [PC_W-1:0] o_dout,
   output logic            o_full,
   output logic            o_empty
);

   logic [PC_W-1:0]      r_mem [RAS_DEPTH];
   logic [RAS_PTR_W-1:0] r_ptr;
   logic [RAS_CNT_W-1:0] r_count;
   logic [RAS_PTR_W-1:0] w_topIdx;

   // r_ptr always names the next free slot, so the top sits one below it.
   // Once the pointer has wrapped, r_ptr also names the oldest entry, which
   // is exactly the slot an overflowing push should replace.
   assign w_topIdx = r_ptr - 1'b1;
   assign o_dout   = r_mem[w_topIdx];
   assign o_full   = (r_count == RAS_CNT_MAX);
   assign o_empty  = (r_count == '0);

   // Storage is deliberately left out of reset; stale entries are never
   // visible because the count gates every read.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_ptr] <= i_din;
      end
   end

   // Pointer and occupancy bookkeeping. The count saturates at the depth
   // because an overflowing push replaces an entry rather than adding one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (i_push) begin
         r_ptr <= r_ptr + 1'b1;
         if (!o_full) begin
            r_count <= r_count + 1'b1;
         end
      end else if (i_pop && !o_empty) begin
         r_ptr   <= r_ptr - 1'b1;
         r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Fetch program counter with branch/jump/call/return redirection. A taken
// control transfer in decode redirects fetch on the next edge and raises
// flush for one cycle so the single wrong-path fetch gets killed.
//
// Build option: define PC_UNIT_RAS_EN to include the 4-entry return stack.
// Without it RET jumps to jumpTarget, CALL pushes nothing and both stack
// error flags read 0.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hazard stall, freezes all state
//   valid_id       in   decode-stage instruction valid
//   opCode[3:0]    in   decode-stage opcode
//   zero           in   branch condition (1 = condition true)
//   branchOffset   in   signed word displacement for branches
//   jumpTarget     in   JMP/CALL target, RET target when no return stack
//   pc             out  fetch address (word address)
//   pc_id          out  address of the instruction in decode
//   flush          out  combinational kill of the fetched instruction
//   ras_overflow   out  sticky: CALL pushed onto a full return stack
//   ras_underflow  out  sticky: RET popped an empty return stack
// ---------------------------------------------------------------------------
module pc_unit
   import processor_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            valid_id,
   input  logic [3:0]      opCode,
   input  logic            zero,
   input  logic [PC_W-1:0] branchOffset,
   input  logic [PC_W-1:0] jumpTarget,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_id,
   output logic            flush,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   pcState_t        r_state;
   pcState_t        w_nextState;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_pcId;
   logic [PC_W-1:0] w_seqPc;
   logic [PC_W-1:0] w_nextPc;
   logic [PC_W-1:0] w_retTarget;
   logic            w_isBranch;
   logic            w_isJmp;
   logic            w_isCall;
   logic            w_isRet;
   logic            w_taken;
   logic            w_advance;
   logic            w_redirect;
   logic            w_flush;

   assign w_isBranch = isBranchOp(opCode);
   assign w_isJmp    = (opCode == OP_JMP);
   assign w_isCall   = (opCode == OP_CALL);
   assign w_isRet    = (opCode == OP_RET);

   // Only branches look at the comparator; JMP/CALL/RET always go
   assign w_taken = valid_id & ((w_isBranch & zero) | w_isJmp | w_isCall | w_isRet);

   assign w_seqPc = r_pc + 1'b1;

   // State register: IDLE after every reset, RUN otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // IDLE is a single settling cycle and always hands over to RUN
   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         ST_IDLE: w_nextState = ST_RUN;
         ST_RUN:  w_nextState = ST_RUN;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Output decode. IDLE flushes whatever the pipeline holds and steps the
   // PC from 0 to 1 without looking at decode. In RUN a stall wins over
   // any redirect, so flush only fires when the redirect actually happens.
   always_comb begin
      w_advance  = 1'b0;
      w_redirect = 1'b0;
      w_flush    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_advance = 1'b1;
            w_flush   = 1'b1;
         end
         ST_RUN: begin
            w_advance  = ~stall;
            w_redirect = ~stall & w_taken;
            w_flush    = w_redirect;
         end
         default: begin
            w_flush = 1'b1;
         end
      endcase
   end

`ifdef PC_UNIT_RAS_EN
   logic            w_push;
   logic            w_pop;
   logic            w_rasFull;
   logic            w_rasEmpty;
   logic [PC_W-1:0] w_rasDout;
   logic [PC_W-1:0] w_retAddr;
   logic            r_rasOverflow;
   logic            r_rasUnderflow;

   assign w_retAddr = r_pcId + 1'b1;
   assign w_push    = w_redirect & w_isCall;
   assign w_pop     = w_redirect & w_isRet;

   return_stack u_returnStack (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_retAddr),
      .o_dout  (w_rasDout),
      .o_full  (w_rasFull),
      .o_empty (w_rasEmpty)
   );

   // An empty-stack RET falls through to the instruction after itself
   assign w_retTarget = w_rasEmpty ? w_retAddr : w_rasDout;

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rasOverflow  <= 1'b0;
         r_rasUnderflow <= 1'b0;
      end else begin
         if (w_push && w_rasFull) begin
            r_rasOverflow <= 1'b1;
         end
         if (w_pop && w_rasEmpty) begin
            r_rasUnderflow <= 1'b1;
         end
      end
   end

   assign ras_overflow  = r_rasOverflow;
   assign ras_underflow = r_rasUnderflow;
`else
   assign w_retTarget   = jumpTarget;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   // Next-PC mux: sequential unless decode redirects. Branch targets are
   // relative to the decoding instruction, not to the fetch address.
   always_comb begin
      w_nextPc = w_seqPc;
      if (w_redirect) begin
         if (w_isBranch) begin
            w_nextPc = r_pcId + branchOffset;
         end else if (w_isJmp || w_isCall) begin
            w_nextPc = jumpTarget;
         end else if (w_isRet) begin
            w_nextPc = w_retTarget;
         end
      end
   end

   // PC pipeline registers. Reset wins over everything, including a
   // redirect that was about to land, so fetch restarts at address 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc   <= '0;
         r_pcId <= '0;
      end else if (w_advance) begin
         r_pc   <= w_nextPc;
         r_pcId <= r_pc;
      end
   end

   assign pc    = r_pc;
   assign pc_id = r_pcId;
   assign flush = w_flush;

endmodule
